// File: rtl/tff_arb_pkg.sv
// Shared types and winner-selection helpers for tff_toggle_arbiter.
package tff_arb_pkg;

   typedef enum logic [1:0] {IDLE = 2'b00, APPLY = 2'b01, DONE = 2'b10} state_t;

   localparam int N_REQ_DEF = 4;
   localparam int WIDTH_DEF = 8;
   localparam int MAX_REQ   = 32;
   localparam int IDX_W     = $clog2(MAX_REQ);

   // First set request strictly after 'last', wrapping over n requesters.
   function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int last, input int n);
      int idx;
      rr_pick = last;
      for (int k = MAX_REQ; k >= 1; k--) begin
         if (k <= n) begin
            idx = (last + k) % n;
            if (req[idx[IDX_W-1:0]]) rr_pick = idx;
         end
      end
   endfunction

   function automatic int fp_pick(input logic [MAX_REQ-1:0] req, input int n);
      fp_pick = 0;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         if (i < n && req[i[IDX_W-1:0]]) fp_pick = i;
      end
   endfunction

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH independent toggle flip-flops with per-bit enables.
module tff_bank #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q
);

   for (genvar k = 0; k < WIDTH; k++) begin : g_tff
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)     q[k] <= 1'b0;
         else if (t[k]) q[k] <= ~q[k];
      end
   end

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter granting one requester's toggle mask to a shared T-FF bank.
// TFF_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module tff_toggle_arbiter
   import tff_arb_pkg::*;
#(
   parameter  int N_REQ = N_REQ_DEF,
   parameter  int WIDTH = WIDTH_DEF,
   localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] mask,
   output logic [N_REQ-1:0]       ack,
   output logic [WIDTH-1:0]       q,
   output logic                   busy,
   output logic [IDW-1:0]         grant_id
);

   state_t                          state, state_nxt;
   logic [WIDTH-1:0]                mask_r, sel_mask, t;
   logic [IDW-1:0]                  win;
   logic [N_REQ-1:0][WIDTH-1:0]     slices;
`ifndef TFF_ARB_FIXED_PRIO_EN
   logic [IDW-1:0]                  last;
`endif

   assign slices = mask;
   assign busy   = (state != IDLE);
   assign t      = (state == APPLY) ? mask_r : '0;

   always_comb begin
`ifdef TFF_ARB_FIXED_PRIO_EN
      win = IDW'(fp_pick(MAX_REQ'(req), N_REQ));
`else
      win = IDW'(rr_pick(MAX_REQ'(req), int'(last), N_REQ));
`endif
      sel_mask = slices[win];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|req) state_nxt = APPLY;
         APPLY:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Mask is latched at grant so later req/mask changes cannot alter the toggle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         mask_r   <= '0;
         grant_id <= '0;
         ack      <= '0;
`ifndef TFF_ARB_FIXED_PRIO_EN
         last     <= IDW'(N_REQ - 1);
`endif
      end else begin
         state <= state_nxt;
         ack   <= '0;
         if (state == IDLE && |req) begin
            mask_r   <= sel_mask;
            grant_id <= win;
`ifndef TFF_ARB_FIXED_PRIO_EN
            last     <= win;
`endif
         end
         if (state == APPLY) ack[grant_id] <= 1'b1;
      end
   end

   tff_bank #(.WIDTH(WIDTH)) u_bank (
      .clk (clk),
      .rst (rst),
      .t   (t),
      .q   (q)
   );

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Scoreboard bench for tff_toggle_arbiter: transaction-level model vs. ack-driven monitor.
module tb_tff_toggle_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [N-1:0]     req = '0;
   logic [N*W-1:0]   mask = '0;
   logic [N-1:0]     ack;
   logic [W-1:0]     q;
   logic             busy;
   logic [1:0]       grant_id;

   tff_toggle_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .mask     (mask),
      .ack      (ack),
      .q        (q),
      .busy     (busy),
      .grant_id (grant_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [W-1:0] q;
   } exp_t;

   exp_t         sb[$];
   int           total = 0;
   int           bad = 0;
   int           drv_to = 0;
   bit           done = 1'b0;

   // reference model state
   int           m_last = N - 1;
   logic [W-1:0] m_q = '0;
   logic [W-1:0] m_mask [N];
   int           cnt [N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   // Winner among requesters that still owe grants.
   function automatic int pick(input int pend [N]);
      int i;
`ifdef TFF_ARB_FIXED_PRIO_EN
      i = 0;
`else
      i = (m_last + 1) % N;
`endif
      while (pend[i] == 0) i = (i + 1) % N;
      return i;
   endfunction

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   // Each requester i wants cnt[i] grants, holding req until its last ack.
   task automatic run_burst(input bit scramble);
      int pend [N];
      int got [N];
      int g, w, lim;
      bit scr_done;
      g = 0;
      for (int i = 0; i < N; i++) begin
         pend[i] = cnt[i];
         got[i]  = 0;
         g      += cnt[i];
      end
      for (int k = 0; k < g; k++) begin
         w = pick(pend);
         pend[w]--;
         m_last = w;
         m_q    = m_q ^ m_mask[w];
         sb.push_back('{id: w, q: m_q});
      end
      for (int i = 0; i < N; i++) begin
         mask[i*W +: W] = m_mask[i];
         req[i]         = (cnt[i] > 0);
      end
      scr_done = 1'b0;
      for (lim = 0; lim < 10*g + 10; lim++) begin
         tick;
         if (scramble && g == 1 && busy && !scr_done) begin
            mask     = ~mask;
            scr_done = 1'b1;
         end
         for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
               got[i]++;
               if (got[i] >= cnt[i]) req[i] = 1'b0;
            end
         end
         if (req == '0 && !busy) break;
      end
      if (lim >= 10*g + 10) begin
         drv_to++;
         req = '0;
      end
   endtask

   task automatic clr_cnt;
      for (int i = 0; i < N; i++) cnt[i] = 0;
   endtask

   // driver
   initial begin
      int lim;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         req  = N'($urandom);
         mask = $urandom;
         tick;
      end
      req  = '0;
      mask = '0;
      rst  = 1'b1;
      tick;

      clr_cnt; cnt[2] = 1; m_mask[2] = 8'hA5;
      run_burst(1'b0);

      clr_cnt; cnt[1] = 2; m_mask[1] = 8'h0F;
      run_burst(1'b0);

      clr_cnt; cnt[3] = 1; m_mask[3] = 8'hFF;
      run_burst(1'b1);

      clr_cnt;
      cnt[0] = 2; cnt[1] = 1; cnt[2] = 1; cnt[3] = 1;
      m_mask[0] = 8'h01; m_mask[1] = 8'h02; m_mask[2] = 8'h04; m_mask[3] = 8'h08;
      run_burst(1'b0);

      clr_cnt; cnt[0] = 1; m_mask[0] = 8'h00;
      run_burst(1'b0);

      // abort a grant while in APPLY, then let the held request win again
      clr_cnt; cnt[2] = 1; m_mask[2] = 8'h3C;
      mask[2*W +: W] = 8'h3C;
      req = 4'b0100;
      for (lim = 0; lim < 10; lim++) begin
         tick;
         if (busy) break;
      end
      if (lim >= 10) drv_to++;
      rst    = 1'b0;
      m_q    = '0;
      m_last = N - 1;
      tick;
      tick;
      rst = 1'b1;
      run_burst(1'b0);

      for (int b = 0; b < 30; b++) begin
         clr_cnt;
         for (int i = 0; i < N; i++) begin
            cnt[i]    = $urandom_range(0, 2);
            m_mask[i] = W'($urandom);
         end
         if (cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0) cnt[$urandom_range(0, N-1)] = 1;
         run_burst(1'($urandom_range(0, 1)));
      end
      tick;
      done = 1'b1;
   end

   // monitor
   initial begin
      exp_t         e;
      logic [N-1:0] ev;
      int           run;
      int           cyc;
      run = 0;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            run = 0;
            chk("rst_q",        32'(q),        32'h0);
            chk("rst_ack",      32'(ack),      32'h0);
            chk("rst_busy",     32'(busy),     32'h0);
            chk("rst_grant_id", 32'(grant_id), 32'h0);
         end else begin
            if (busy) run++;
            else begin
               if (run != 0) chk("busy_len", 32'(run), 32'd2);
               run = 0;
            end
            if (ack != '0) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL ack_unexpected got=%b want=none", ack);
               end else begin
                  e = sb.pop_front();
                  ev = '0;
                  ev[e.id] = 1'b1;
                  chk("ack_vec",   32'(ack),      32'(ev));
                  chk("q_at_ack",  32'(q),        32'(e.q));
                  chk("grant_id",  32'(grant_id), 32'(e.id));
                  chk("ack_phase", 32'(run),      32'd2);
               end
            end
         end
         if (done || cyc > 60000) begin
            chk("watchdog",   32'(done),      32'd1);
            chk("sb_empty",   32'(sb.size()), 32'd0);
            chk("drv_timeout", 32'(drv_to),   32'd0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
      end
   end

endmodule
